// File: rtl/udp_checksum_pkg.sv
// Shared constants, header record, FSM states and ones-complement fold helper
// for the UDP checksum/length generator.
package udp_checksum_pkg;

  localparam int         UDP_HDR_BYTES = 8;
  localparam logic [7:0] IP_PROTO_UDP  = 8'h11;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    FOLD,
    FINAL,
    HDR_OUT,
    DATA_OUT
  } state_t;

  // Header fields carried through unchanged (length/checksum are regenerated)
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  ttl;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } udp_hdr_t;

  // One ones-complement carry fold: high half added into low half
  function automatic logic [16:0] fold16(input logic [31:0] s);
    return {1'b0, s[15:0]} + {1'b0, s[31:16]};
  endfunction

endpackage

// File: rtl/udp_payload_fifo.sv
// Single-clock byte FIFO with show-ahead read data. Holds {tuser, tlast, tdata}
// per entry; clear empties it in one cycle and wins over a same-cycle write.
module udp_payload_fifo #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/udp_checksum_gen_wrapper.sv
// Store-and-forward UDP length/checksum generator: latches one header, buffers
// and sums its payload, then emits the completed header and replays the bytes.
module udp_checksum_gen_wrapper
  import udp_checksum_pkg::*;
#(
  parameter int PAYLOAD_FIFO_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        reset,
  // payload in
  input  logic [7:0]  axis_payload_in_tdata,
  input  logic        axis_payload_in_tvalid,
  output logic        axis_payload_in_tready,
  input  logic        axis_payload_in_tlast,
  input  logic        axis_payload_in_tkeep,
  input  logic [7:0]  axis_payload_in_tid,
  input  logic [7:0]  axis_payload_in_tdest,
  input  logic        axis_payload_in_tuser,
  // header in
  input  logic        udp_in_udp_hdr_valid,
  output logic        udp_in_udp_hdr_ready,
  input  logic [31:0] udp_in_src_ip,
  input  logic [31:0] udp_in_dst_ip,
  input  logic [7:0]  udp_in_ttl,
  input  logic [15:0] udp_in_src_port,
  input  logic [15:0] udp_in_dst_port,
  input  logic [15:0] udp_in_udp_length,
  input  logic [15:0] udp_in_udp_checksum,
  // payload out
  output logic [7:0]  axis_payload_out_tdata,
  output logic        axis_payload_out_tvalid,
  input  logic        axis_payload_out_tready,
  output logic        axis_payload_out_tlast,
  output logic        axis_payload_out_tkeep,
  output logic [7:0]  axis_payload_out_tid,
  output logic [7:0]  axis_payload_out_tdest,
  output logic        axis_payload_out_tuser,
  // header out
  output logic        udp_out_udp_hdr_valid,
  input  logic        udp_out_udp_hdr_ready,
  output logic [31:0] udp_out_src_ip,
  output logic [31:0] udp_out_dst_ip,
  output logic [7:0]  udp_out_ttl,
  output logic [15:0] udp_out_src_port,
  output logic [15:0] udp_out_dst_port,
  output logic [15:0] udp_out_udp_length,
  output logic [15:0] udp_out_udp_checksum,
  output logic        busy
);

  state_t      state, state_n;
  udp_hdr_t    hdr;
  logic [31:0] sum;
  logic [15:0] count, len_r, csum_r;
  logic        dropped;

  logic        hdr_fire, in_fire;
  logic        fifo_full, fifo_empty, fifo_clear, fifo_wr, fifo_rd;
  logic [9:0]  fifo_rd_data;
  logic [31:0] pseudo_sum, byte_word;
  logic [15:0] len_w, fin_fold, csum_w;
  logic        unused_in;

  // Sideband the design does not consume; input length/checksum are regenerated
  assign unused_in = ^{axis_payload_in_tkeep, axis_payload_in_tid, axis_payload_in_tdest,
                       udp_in_udp_length, udp_in_udp_checksum};

  assign hdr_fire = udp_in_udp_hdr_valid & udp_in_udp_hdr_ready;
  assign in_fire  = axis_payload_in_tvalid & axis_payload_in_tready;
  assign fifo_wr  = in_fire & ~dropped & ~fifo_full;
  assign fifo_rd  = axis_payload_out_tvalid & axis_payload_out_tready;

  // Pseudo-header addresses/protocol plus UDP ports; length is added at FOLD
  assign pseudo_sum = 32'(udp_in_src_ip[31:16]) + 32'(udp_in_src_ip[15:0])
                    + 32'(udp_in_dst_ip[31:16]) + 32'(udp_in_dst_ip[15:0])
                    + 32'(IP_PROTO_UDP)
                    + 32'(udp_in_src_port) + 32'(udp_in_dst_port);

  // Even byte offset lands in the high half of a 16-bit word
  assign byte_word = count[0] ? {24'd0, axis_payload_in_tdata}
                              : {16'd0, axis_payload_in_tdata, 8'd0};
  assign len_w     = 16'(UDP_HDR_BYTES) + count;
  // After FOLD the sum is at most 17 bits, so a second fold cannot carry out
  assign fin_fold  = 16'(fold16(sum));
  assign csum_w    = (fin_fold == 16'hFFFF) ? 16'hFFFF : ~fin_fold;

  udp_payload_fifo #(
    .DEPTH (PAYLOAD_FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (fifo_clear),
    .wr_en   (fifo_wr),
    .wr_data ({axis_payload_in_tuser, axis_payload_in_tlast, axis_payload_in_tdata}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n                 = state;
    udp_in_udp_hdr_ready    = 1'b0;
    axis_payload_in_tready  = 1'b0;
    udp_out_udp_hdr_valid   = 1'b0;
    axis_payload_out_tvalid = 1'b0;
    fifo_clear              = 1'b0;
    case (state)
      IDLE: begin
        udp_in_udp_hdr_ready = ~reset;
        if (udp_in_udp_hdr_valid && !reset) state_n = PAYLOAD;
      end
      PAYLOAD: begin
        axis_payload_in_tready = 1'b1;
        if (axis_payload_in_tvalid && axis_payload_in_tlast) begin
          // overflow on this or an earlier beat: discard the whole frame
          if (dropped || fifo_full) begin
            fifo_clear = 1'b1;
            state_n    = IDLE;
          end else begin
            state_n = FOLD;
          end
        end
      end
      FOLD:  state_n = FINAL;
      FINAL: state_n = HDR_OUT;
      HDR_OUT: begin
        udp_out_udp_hdr_valid = 1'b1;
        if (udp_out_udp_hdr_ready) state_n = DATA_OUT;
      end
      DATA_OUT: begin
        axis_payload_out_tvalid = ~fifo_empty;
        if (!fifo_empty && axis_payload_out_tready && fifo_rd_data[8]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Header capture, running sum, byte count and the two fold steps
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr     <= '0;
      sum     <= '0;
      count   <= '0;
      dropped <= 1'b0;
      len_r   <= '0;
      csum_r  <= '0;
    end else begin
      case (state)
        IDLE: if (hdr_fire) begin
          hdr     <= '{src_ip:   udp_in_src_ip,   dst_ip:   udp_in_dst_ip,
                       ttl:      udp_in_ttl,
                       src_port: udp_in_src_port, dst_port: udp_in_dst_port};
          sum     <= pseudo_sum;
          count   <= '0;
          dropped <= 1'b0;
        end
        PAYLOAD: if (in_fire) begin
          sum   <= sum + byte_word;
          count <= count + 16'd1;
          if (fifo_full) dropped <= 1'b1;
        end
        FOLD: begin
          // length appears twice: pseudo-header and UDP header
          sum   <= 32'(fold16(sum + {15'd0, len_w, 1'b0}));
          len_r <= len_w;
        end
        FINAL:   csum_r <= csum_w;
        default: ;
      endcase
    end
  end

  assign udp_out_src_ip       = hdr.src_ip;
  assign udp_out_dst_ip       = hdr.dst_ip;
  assign udp_out_ttl          = hdr.ttl;
  assign udp_out_src_port     = hdr.src_port;
  assign udp_out_dst_port     = hdr.dst_port;
  assign udp_out_udp_length   = len_r;
  assign udp_out_udp_checksum = csum_r;

  assign axis_payload_out_tdata = fifo_rd_data[7:0];
  assign axis_payload_out_tlast = fifo_rd_data[8];
  assign axis_payload_out_tuser = fifo_rd_data[9];
  assign axis_payload_out_tkeep = 1'b1;
  assign axis_payload_out_tid   = 8'd0;
  assign axis_payload_out_tdest = 8'd0;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_udp_checksum_gen_wrapper.sv
// Randomized + directed bench for udp_checksum_gen_wrapper against a
// word-summing ones-complement reference model.
module tb_udp_checksum_gen_wrapper;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_tdata;
  logic        in_tvalid, in_tready, in_tlast, in_tkeep, in_tuser;
  logic [7:0]  in_tid, in_tdest;
  logic        ih_valid, ih_ready;
  logic [31:0] ih_src, ih_dst;
  logic [7:0]  ih_ttl;
  logic [15:0] ih_sp, ih_dp, ih_len, ih_csum;
  logic [7:0]  out_tdata;
  logic        out_tvalid, out_tready, out_tlast, out_tkeep, out_tuser;
  logic [7:0]  out_tid, out_tdest;
  logic        oh_valid, oh_ready;
  logic [31:0] oh_src, oh_dst;
  logic [7:0]  oh_ttl;
  logic [15:0] oh_sp, oh_dp, oh_len, oh_csum;
  logic        busy;

  always #5 clk = ~clk;

  udp_checksum_gen_wrapper #(.PAYLOAD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .axis_payload_in_tdata(in_tdata), .axis_payload_in_tvalid(in_tvalid),
    .axis_payload_in_tready(in_tready), .axis_payload_in_tlast(in_tlast),
    .axis_payload_in_tkeep(in_tkeep), .axis_payload_in_tid(in_tid),
    .axis_payload_in_tdest(in_tdest), .axis_payload_in_tuser(in_tuser),
    .udp_in_udp_hdr_valid(ih_valid), .udp_in_udp_hdr_ready(ih_ready),
    .udp_in_src_ip(ih_src), .udp_in_dst_ip(ih_dst), .udp_in_ttl(ih_ttl),
    .udp_in_src_port(ih_sp), .udp_in_dst_port(ih_dp),
    .udp_in_udp_length(ih_len), .udp_in_udp_checksum(ih_csum),
    .axis_payload_out_tdata(out_tdata), .axis_payload_out_tvalid(out_tvalid),
    .axis_payload_out_tready(out_tready), .axis_payload_out_tlast(out_tlast),
    .axis_payload_out_tkeep(out_tkeep), .axis_payload_out_tid(out_tid),
    .axis_payload_out_tdest(out_tdest), .axis_payload_out_tuser(out_tuser),
    .udp_out_udp_hdr_valid(oh_valid), .udp_out_udp_hdr_ready(oh_ready),
    .udp_out_src_ip(oh_src), .udp_out_dst_ip(oh_dst), .udp_out_ttl(oh_ttl),
    .udp_out_src_port(oh_sp), .udp_out_dst_port(oh_dp),
    .udp_out_udp_length(oh_len), .udp_out_udp_checksum(oh_csum),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] h_src, h_dst;
  logic [15:0] h_sp, h_dp;
  logic [7:0]  h_ttl;
  logic [7:0]  pl[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: RFC 768 checksum over pseudo-header, header and zero-padded payload
  function automatic logic [15:0] ref_csum(input logic [31:0] s, input logic [31:0] d,
                                           input logic [15:0] sp, input logic [15:0] dp);
    longint unsigned acc;
    longint unsigned l;
    logic [15:0] c;
    l   = 8 + pl.size();
    acc = longint'(s[31:16]) + longint'(s[15:0]) + longint'(d[31:16]) + longint'(d[15:0])
        + 17 + l + longint'(sp) + longint'(dp) + l;
    for (int i = 0; i < pl.size(); i++)
      acc += (i % 2 == 0) ? longint'(pl[i]) * 256 : longint'(pl[i]);
    while (acc > 65535) acc = (acc & 65535) + (acc >> 16);
    c = ~acc[15:0];
    return (c == 16'h0000) ? 16'hFFFF : c;
  endfunction

  task automatic set_common();
    h_src = 32'hC0A80180; h_dst = 32'hC0A8017F;
    h_sp  = 16'd3001;     h_dp  = 16'd3000; h_ttl = 8'd64;
  endtask

  task automatic send_hdr();
    ih_src = h_src; ih_dst = h_dst; ih_sp = h_sp; ih_dp = h_dp; ih_ttl = h_ttl;
    ih_len = 16'($urandom); ih_csum = 16'($urandom);
    ih_valid = 1'b1;
    for (int k = 0; k < 100 && !ih_ready; k++) tick();
    chk("hdr_in_ready", ih_ready, 1);
    tick();
    ih_valid = 1'b0;
    chk("busy_after_hdr", busy, 1);
  endtask

  task automatic send_payload(input int gap, input logic tu);
    for (int i = 0; i < pl.size(); i++) begin
      repeat ($urandom_range(gap, 0)) tick();
      in_tdata  = pl[i];
      in_tlast  = (i == pl.size() - 1);
      in_tuser  = in_tlast ? tu : 1'($urandom);
      in_tkeep  = 1'($urandom);
      in_tvalid = 1'b1;
      for (int k = 0; k < 100 && !in_tready; k++) tick();
      if (!in_tready) begin
        chk("payload_in_timeout", in_tready, 1);
        in_tvalid = 1'b0;
        return;
      end
      tick();
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
    end
  endtask

  task automatic recv_frame(input int hold, input logic [15:0] fixed, input logic tu);
    logic [15:0] exp_c;
    int i, k;
    exp_c = ref_csum(h_src, h_dst, h_sp, h_dp);
    for (k = 0; k < 50 && !oh_valid; k++) tick();
    chk("hdr_out_valid", oh_valid, 1);
    if (!oh_valid) return;
    for (int j = 0; j < hold; j++) begin
      chk("hold_state", {oh_valid, out_tvalid, ih_ready, in_tready, busy, oh_csum},
          {5'b10001, exp_c});
      tick();
    end
    chk("csum", oh_csum, exp_c);
    if (fixed != 16'h0) chk("csum_fixed", oh_csum, fixed);
    chk("len", oh_len, 8 + pl.size());
    chk("src_ip", oh_src, h_src);
    chk("dst_ip", oh_dst, h_dst);
    chk("ports", {oh_sp, oh_dp}, {h_sp, h_dp});
    chk("ttl", oh_ttl, h_ttl);
    oh_ready = 1'b1;
    tick();
    oh_ready = 1'b0;
    chk("first_beat_valid", out_tvalid, 1);
    i = 0; k = 0;
    while (i < pl.size() && k < 2000) begin
      out_tready = (i == 0) || ($urandom_range(3, 0) != 0);
      if (out_tvalid && out_tready) begin
        chk("data", out_tdata, pl[i]);
        chk("tlast", out_tlast, (i == pl.size() - 1));
        chk("side", {out_tkeep, out_tid, out_tdest}, 17'h10000);
        if (i == pl.size() - 1) chk("tuser", out_tuser, tu);
        i++;
      end
      tick();
      k++;
    end
    out_tready = 1'b0;
    chk("beats", i, pl.size());
    chk("busy_end", busy, 0);
  endtask

  task automatic run_frame(input int gap, input int hold, input logic [15:0] fixed);
    logic tu;
    tu = 1'($urandom);
    send_hdr();
    send_payload(gap, tu);
    chk("lat_n1", oh_valid, 0);
    tick();
    chk("lat_n2", oh_valid, 0);
    tick();
    chk("lat_n3", oh_valid, 1);
    recv_frame(hold, fixed, tu);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames, since, seen, n;
    reset = 1'b1;
    in_tdata = 0; in_tvalid = 0; in_tlast = 0; in_tkeep = 0; in_tid = 0; in_tdest = 0; in_tuser = 0;
    ih_valid = 0; ih_src = 0; ih_dst = 0; ih_ttl = 0; ih_sp = 0; ih_dp = 0; ih_len = 0; ih_csum = 0;
    out_tready = 0; oh_ready = 0;
    repeat (3) tick();
    chk("reset_out", {ih_ready, in_tready, oh_valid, out_tvalid, busy}, 0);
    reset = 1'b0;
    tick();

    // directed: common header, small payloads
    set_common(); pl = {8'h00};             run_frame(0, 0, 16'h641B);
    set_common(); pl = {8'h12, 8'h34};      run_frame(1, 0, 16'h51E5);
    set_common(); pl = {8'h01, 8'h02, 8'h03}; run_frame(0, 0, 16'h6015);
    // header output held off for 5 cycles
    set_common(); pl = {8'hA5, 8'h5A};      run_frame(0, 5, 16'h0);

    // back-to-back saturated inputs: each frame exactly one header then one beat
    set_common(); pl = {8'h00};
    ih_src = h_src; ih_dst = h_dst; ih_sp = h_sp; ih_dp = h_dp; ih_ttl = h_ttl;
    ih_valid = 1; in_tvalid = 1; in_tlast = 1; in_tdata = 0; in_tuser = 0;
    oh_ready = 1; out_tready = 1;
    frames = 0; since = 0;
    for (int c = 0; c < 200; c++) begin
      if (frames >= 10 && ih_ready) break;
      if (oh_valid) begin
        chk("sat_hdr", {oh_csum, oh_len}, {16'h641B, 16'd9});
        if (frames > 0) chk("sat_merge", since, 1);
        frames++;
        since = 0;
      end
      if (out_tvalid) begin
        chk("sat_beat", {out_tdata, out_tlast}, {8'h00, 1'b1});
        since++;
      end
      tick();
    end
    ih_valid = 0; in_tvalid = 0; in_tlast = 0;
    chk("sat_frames", (frames >= 10), 1);
    tick();
    oh_ready = 0; out_tready = 0;

    // reset mid-payload discards state
    set_common(); pl = {8'h00};
    send_hdr();
    in_tdata = 8'hAA; in_tlast = 0; in_tvalid = 1;
    tick();
    in_tvalid = 0;
    reset = 1;
    tick();
    chk("rst_mid_out", {ih_ready, in_tready, oh_valid, out_tvalid, busy}, 0);
    reset = 0;
    tick();
    run_frame(0, 0, 16'h641B);

    // overflowing frame is dropped with no output
    set_common(); pl.delete();
    for (int i = 0; i < DEPTH + 5; i++) pl.push_back(8'($urandom));
    send_hdr();
    send_payload(0, 1'b0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (oh_valid || out_tvalid) seen = 1;
      tick();
    end
    chk("drop_no_output", seen, 0);
    chk("drop_idle", {busy, ih_ready}, 2'b01);

    // exactly full buffer is still forwarded
    set_common(); pl.delete();
    for (int i = 0; i < DEPTH; i++) pl.push_back(8'($urandom));
    run_frame(0, 0, 16'h0);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      h_src = $urandom; h_dst = $urandom; h_sp = 16'($urandom); h_dp = 16'($urandom);
      h_ttl = 8'($urandom);
      n = ($urandom_range(5, 0) == 0) ? DEPTH : $urandom_range(40, 1);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_frame($urandom_range(2, 0), $urandom_range(3, 0), 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
